// File: rtl/playback_controller.sv
// ---------------------------------------------------------------------------
// playback_controller
// Record/playback sequencer for a 16-entry note memory. A rising edge on
// rec_req stores the current note (two-cycle ld_note strobe). A rising edge
// on play_req steps through the stored notes, holding each one for
// NOTE_TICKS clock cycles. Playback starts at the oldest entry when the
// buffer is full, otherwise at address 1.
//
// Build option:
//   PLAY_LOOP_EN - when defined, playback restarts at the start address after
//                  the last note and runs until stop_req or reset. When
//                  undefined, playback returns to IDLE after the last note.
// ---------------------------------------------------------------------------
module playback_controller #(
    parameter int NOTE_TICKS = 12500000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rec_req,
    input  logic       play_req,
    input  logic       stop_req,
    output logic       ld_note,
    output logic       ld_play,
    output logic [3:0] note_counter,
    output logic       display_note,
    output logic [4:0] note_count,
    output logic       playing
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REC1      = 2'd1,
        REC2      = 2'd2,
        PLAY_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(NOTE_TICKS - 1);

    state_t           state_q;
    logic             rec_q;
    logic             play_q;
    logic [3:0]       wr_ptr_q;
    logic [4:0]       note_count_q;
    logic [4:0]       idx_q;
    logic [CNT_W-1:0] tick_q;
    logic [CNT_W-1:0] tick_d;
    logic [3:0]       note_counter_q;
    logic             ld_note_q;
    logic             ld_play_q;
    logic             display_q;
    logic             playing_q;

    logic             rec_edge_s;
    logic             play_edge_s;
    logic             full_s;
    logic [3:0]       start_addr_s;

    assign rec_edge_s   = rec_req & ~rec_q;
    assign play_edge_s  = play_req & ~play_q;
    assign full_s       = (note_count_q == 5'd16);
    // A full buffer has wrapped, so the oldest entry sits just past wr_ptr.
    assign start_addr_s = full_s ? (wr_ptr_q + 4'd1) : 4'd1;
    assign tick_d       = tick_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Request synchronisation registers used for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_q  <= 1'b0;
            play_q <= 1'b0;
        end else begin
            rec_q  <= rec_req;
            play_q <= play_req;
        end
    end

    // Main sequencer FSM with all datapath-facing outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= 4'd0;
            note_count_q   <= 5'd0;
            idx_q          <= 5'd0;
            tick_q         <= '0;
            note_counter_q <= 4'd0;
            ld_note_q      <= 1'b0;
            ld_play_q      <= 1'b0;
            display_q      <= 1'b0;
            playing_q      <= 1'b0;
        end else begin
            display_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rec_edge_s) begin
                        // Record wins over a simultaneous play request.
                        state_q   <= REC1;
                        ld_note_q <= 1'b1;
                    end else if (play_edge_s && (note_count_q != 5'd0)) begin
                        state_q        <= PLAY_HOLD;
                        note_counter_q <= start_addr_s;
                        tick_q         <= '0;
                        idx_q          <= 5'd1;
                        display_q      <= 1'b1;
                        ld_play_q      <= 1'b1;
                        playing_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REC1: begin
                    state_q <= REC2;
                end
                REC2: begin
                    state_q   <= IDLE;
                    ld_note_q <= 1'b0;
                    wr_ptr_q  <= wr_ptr_q + 4'd1;
                    if (!full_s) begin
                        note_count_q <= note_count_q + 5'd1;
                    end else begin
                        note_count_q <= note_count_q;
                    end
                end
                PLAY_HOLD: begin
                    if (stop_req) begin
                        state_q   <= IDLE;
                        tick_q    <= '0;
                        ld_play_q <= 1'b0;
                        playing_q <= 1'b0;
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (idx_q < note_count_q) begin
                            note_counter_q <= note_counter_q + 4'd1;
                            idx_q          <= idx_q + 5'd1;
                            display_q      <= 1'b1;
                        end else begin
`ifdef PLAY_LOOP_EN
                            note_counter_q <= start_addr_s;
                            idx_q          <= 5'd1;
                            display_q      <= 1'b1;
`else
                            state_q   <= IDLE;
                            ld_play_q <= 1'b0;
                            playing_q <= 1'b0;
`endif
                        end
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ld_note_q <= 1'b0;
                    ld_play_q <= 1'b0;
                    playing_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_note      = ld_note_q;
    assign ld_play      = ld_play_q;
    assign note_counter = note_counter_q;
    assign display_note = display_q;
    assign note_count   = note_count_q;
    assign playing      = playing_q;

endmodule

// File: doc/playback_controller.md
PLAYBACK_CONTROLLER -- requirements
Module: playback_controller

Interface
REQ-001 Parameter NOTE_TICKS, default 12500000: clk cycles each note is held during playback (0.25 s at 50 MHz); legal range 2..2^26-1.
REQ-002 Parameter CNT_W, default 26: width of the hold-tick counter; SHALL satisfy 2^CNT_W > NOTE_TICKS.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rec_req  input  1  level request to store the current note; acted on at its rising edge.
REQ-006 play_req  input  1  level request to start playback; acted on at its rising edge.
REQ-007 stop_req  input  1  level request to abort playback; acted on whenever high.
REQ-008 ld_note  output  1  store strobe to the datapath.
REQ-009 ld_play  output  1  playback select to the datapath.
REQ-010 note_counter  output  4  memory address to play.
REQ-011 display_note  output  1  one-cycle pulse at the start of each played note.
REQ-012 note_count  output  5  number of stored notes, 0..16.
REQ-013 playing  output  1  high while in PLAY_HOLD.

Function
REQ-014 Edge detect: rec_req/play_req SHALL be registered once; the "edge" is current high and registered value low.
REQ-015 FSM states SHALL be IDLE, REC1, REC2, PLAY_HOLD; reset state IDLE.
REQ-016 IDLE: rec edge -> REC1; otherwise play edge with note_count>0 -> PLAY_HOLD; play edge with note_count==0 is ignored.
REQ-017 Simultaneous rec and play edges in IDLE: rec wins, play edge is discarded.
REQ-018 REC1 -> REC2 -> IDLE unconditionally; ld_note SHALL be high in REC1 and REC2 only (exactly 2 cycles per store).
REQ-019 On leaving REC2: wr_ptr (4-bit, reset 0) increments mod 16; note_count increments, saturating at 16.
REQ-020 Playback start address: wr_ptr+1 if note_count<16 is false (buffer full), else 1; i.e. full -> oldest entry first, not full -> address 1.
REQ-021 Entering PLAY_HOLD: note_counter <= start address, tick counter <= 0, played index <= 1, display_note pulses in the first PLAY_HOLD cycle.
REQ-022 PLAY_HOLD: ld_play high; tick counter increments each cycle; at tick==NOTE_TICKS-1, tick counter <= 0 and advance.
REQ-023 Advance with index<note_count: note_counter increments mod 16 (15 -> 0), index increments, display_note pulses the next cycle.
REQ-024 Advance with index==note_count: end of sequence (see REQ-031/032).
REQ-025 stop_req high in PLAY_HOLD SHALL force IDLE on the next edge, overriding any advance; ld_play low from that cycle.
REQ-026 rec and play edges during PLAY_HOLD and REC1/REC2 SHALL be ignored (not queued).
REQ-027 ld_note and ld_play SHALL never be high in the same cycle.
REQ-028 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset high SHALL immediately force: state IDLE, ld_note 0, ld_play 0, note_counter 0, display_note 0, note_count 0, playing 0, wr_ptr 0, tick counter 0, edge registers 0.
REQ-030 Reset mid-playback or mid-store SHALL abandon the operation; no store is counted if reset occurs in REC1/REC2.

Configuration
REQ-031 Macro PLAY_LOOP_EN defined: end of sequence SHALL restart at the start address with index 1 and pulse display_note; playback continues until stop_req or reset.
REQ-032 PLAY_LOOP_EN undefined: end of sequence SHALL return to IDLE; ld_play and playing drop on the following cycle.

Verification
REQ-033 Reset, rec_req pulse (NOTE_TICKS=4) -> ld_note high exactly 2 cycles, note_count 1, no ld_play.
REQ-034 3 stores then play_req -> note_counter 1,2,3 each for 4 cycles, 3 display_note pulses, then IDLE (loop off) or back to 1 (loop on).
REQ-035 18 stores then play_req -> note_count 16, playback starts at address 3, wraps 15 -> 0, ends at 2.
REQ-036 play_req with note_count 0 -> stays IDLE, ld_play never asserted; rec+play same cycle -> only ld_note strobe.
REQ-037 stop_req during 2nd note -> ld_play low next cycle, state IDLE; reset asserted mid-REC1 -> all outputs 0 asynchronously, note_count 0.
